// File: rtl/amber_wb_inst_feeder_pkg.sv
// Shared types and helpers for the Amber Wishbone instruction feeder.
//   feed_state_t : feeder FSM states
//   AMBER_NOP    : default filler word (MOV r1, r3 style NOP used by the bench)
//   sel_to_lane  : maps a 16-bit byte select to a single 32-bit lane index
package target_package;

    localparam logic [31:0] AMBER_NOP = 32'hF0801003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_ACK,
        ST_ERR,
        ST_WR_HOLD
    } feed_state_t;

    typedef struct packed {
        logic       ok;    // exactly one nonzero nibble
        logic [1:0] lane;  // index of that nibble
    } lane_sel_t;

    // A store must touch exactly one 32-bit lane; anything else is an error.
    function automatic lane_sel_t sel_to_lane(input logic [15:0] sel);
        lane_sel_t  r;
        logic [2:0] n;
        r = '0;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (sel[4*i +: 4] != 4'h0) begin
                n      = n + 3'd1;
                r.lane = 2'(i);
            end
        end
        r.ok = (n == 3'd1);
        return r;
    endfunction

endpackage

// File: rtl/amber_wb_inst_feeder_sync_fifo.sv
// amber_sync_fifo: 32-bit synchronous FIFO with level output.
//   i_clk, i_rst_n    : clock, async active-low reset (flushes pointers)
//   i_push / i_data   : write port (ignored when full)
//   i_pop  / o_data   : read port, o_data is the current head (ignored when empty)
//   o_level, o_empty  : occupancy
// Pointers carry one extra MSB so full and empty are distinguishable.
module amber_sync_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [31:0]             i_data,
    input  logic                    i_pop,
    output logic [31:0]             o_data,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_c;
    logic          push_ok_c;
    logic          pop_ok_c;

    // Occupancy and guarded handshakes
    always_comb begin
        o_empty   = (wr_ptr_q == rd_ptr_q);
        full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_ok_c = i_push && !full_c;
        pop_ok_c  = i_pop && !o_empty;
        wr_ptr_d  = wr_ptr_q + PW'(push_ok_c);
        rd_ptr_d  = rd_ptr_q + PW'(pop_ok_c);
        o_level   = wr_ptr_q - rd_ptr_q;
        o_data    = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; pointers define validity
    always_ff @(posedge i_clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/amber_wb_inst_feeder.sv
// amber_wb_inst_feeder: Wishbone slave feeding instructions to the Amber core.
//   i_inst_valid/o_inst_ready/i_inst : instruction push into the FIFO
//   i_wb_*                           : core Wishbone request (128-bit data)
//   o_wb_dat/o_wb_ack/o_wb_err       : response; dat holds until next read ack
//   o_st_valid/i_st_ready/o_st_*     : one-entry captured-store buffer
//   o_level, o_fetch_pc              : FIFO occupancy, last acked read address
// Build option AMBER_FEED_NOP_ON_EMPTY_EN: empty-FIFO reads ack at once with
// an all-NOP line instead of stalling in RD_WAIT.
module amber_wb_inst_feeder
    import target_package::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] NOP_WORD = AMBER_NOP
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_inst_valid,
    output logic                    o_inst_ready,
    input  logic [31:0]             i_inst,
    input  logic [31:0]             i_wb_adr,
    input  logic [15:0]             i_wb_sel,
    input  logic                    i_wb_we,
    input  logic [127:0]            i_wb_dat,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    output logic [127:0]            o_wb_dat,
    output logic                    o_wb_ack,
    output logic                    o_wb_err,
    output logic                    o_st_valid,
    input  logic                    i_st_ready,
    output logic [31:0]             o_st_adr,
    output logic [31:0]             o_st_dat,
    output logic [3:0]              o_st_sel,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic [31:0]             o_fetch_pc
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    feed_state_t   state_q, state_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [3:0]    wnib_q, wnib_d;
    logic [127:0]  dat_q, dat_d;
    logic [31:0]   pc_q, pc_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          st_valid_q, st_valid_d;
    logic [31:0]   st_adr_q, st_adr_d;
    logic [31:0]   st_dat_q, st_dat_d;
    logic [3:0]    st_sel_q, st_sel_d;

    logic          fifo_push_c;
    logic          fifo_pop_c;
    logic [31:0]   fifo_data_c;
    logic          fifo_empty_c;
    logic          req_c;
    logic          st_free_c;
    lane_sel_t     wsel_c;

    // Place one instruction in its lane, NOP elsewhere
    function automatic logic [127:0] place_word(input logic [31:0] w, input logic [1:0] lane);
        logic [127:0] line;
        line = {4{NOP_WORD}};
        line[{lane, 5'd0} +: 32] = w;
        return line;
    endfunction

    assign o_inst_ready = (o_level != LW'(DEPTH));
    assign fifo_push_c  = i_inst_valid && o_inst_ready;

    amber_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push_c),
        .i_data  (i_inst),
        .i_pop   (fifo_pop_c),
        .o_data  (fifo_data_c),
        .o_level (o_level),
        .o_empty (fifo_empty_c)
    );

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        wnib_d     = wnib_q;
        dat_d      = dat_q;
        pc_d       = pc_q;
        st_adr_d   = st_adr_q;
        st_dat_d   = st_dat_q;
        st_sel_d   = st_sel_q;
        fifo_pop_c = 1'b0;
        req_c      = i_wb_cyc && i_wb_stb;
        wsel_c     = sel_to_lane(i_wb_sel);
        // A drain this cycle frees the slot for a same-cycle capture
        st_free_c  = !st_valid_q || i_st_ready;
        st_valid_d = st_valid_q && !i_st_ready;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    adr_d = i_wb_adr;
                    if (!i_wb_we) begin
                        if (!fifo_empty_c) begin
                            fifo_pop_c = 1'b1;
                            dat_d      = place_word(fifo_data_c, i_wb_adr[3:2]);
                            pc_d       = i_wb_adr;
                            state_d    = ST_ACK;
                        end else begin
`ifdef AMBER_FEED_NOP_ON_EMPTY_EN
                            dat_d   = {4{NOP_WORD}};
                            pc_d    = i_wb_adr;
                            state_d = ST_ACK;
`else
                            state_d = ST_RD_WAIT;
`endif
                        end
                    end else if (!wsel_c.ok) begin
                        state_d = ST_ERR;
                    end else begin
                        wdat_d = i_wb_dat[{wsel_c.lane, 5'd0} +: 32];
                        wnib_d = i_wb_sel[{wsel_c.lane, 2'd0} +: 4];
                        if (st_free_c) begin
                            st_valid_d = 1'b1;
                            st_adr_d   = i_wb_adr;
                            st_dat_d   = i_wb_dat[{wsel_c.lane, 5'd0} +: 32];
                            st_sel_d   = i_wb_sel[{wsel_c.lane, 2'd0} +: 4];
                            state_d    = ST_ACK;
                        end else begin
                            state_d = ST_WR_HOLD;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                if (!fifo_empty_c) begin
                    fifo_pop_c = 1'b1;
                    dat_d      = place_word(fifo_data_c, adr_q[3:2]);
                    pc_d       = adr_q;
                    state_d    = ST_ACK;
                end
            end
            ST_WR_HOLD: begin
                if (st_free_c) begin
                    st_valid_d = 1'b1;
                    st_adr_d   = adr_q;
                    st_dat_d   = wdat_q;
                    st_sel_d   = wnib_q;
                    state_d    = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ack_d = (state_d == ST_ACK);
        err_d = (state_d == ST_ERR);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            wdat_q     <= '0;
            wnib_q     <= '0;
            dat_q      <= {4{NOP_WORD}};
            pc_q       <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            st_valid_q <= 1'b0;
            st_adr_q   <= '0;
            st_dat_q   <= '0;
            st_sel_q   <= '0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            wnib_q     <= wnib_d;
            dat_q      <= dat_d;
            pc_q       <= pc_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            st_valid_q <= st_valid_d;
            st_adr_q   <= st_adr_d;
            st_dat_q   <= st_dat_d;
            st_sel_q   <= st_sel_d;
        end
    end

    assign o_wb_dat   = dat_q;
    assign o_wb_ack   = ack_q;
    assign o_wb_err   = err_q;
    assign o_fetch_pc = pc_q;
    assign o_st_valid = st_valid_q;
    assign o_st_adr   = st_adr_q;
    assign o_st_dat   = st_dat_q;
    assign o_st_sel   = st_sel_q;

endmodule

// File: tb/tb_amber_wb_inst_feeder.sv
// Directed self-checking bench for amber_wb_inst_feeder (DEPTH 8).
module tb_amber_wb_inst_feeder;

    localparam logic [31:0] NOP = 32'hF0801003;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_inst_valid;
    logic         o_inst_ready;
    logic [31:0]  i_inst;
    logic [31:0]  i_wb_adr;
    logic [15:0]  i_wb_sel;
    logic         i_wb_we;
    logic [127:0] i_wb_dat;
    logic         i_wb_cyc;
    logic         i_wb_stb;
    logic [127:0] o_wb_dat;
    logic         o_wb_ack;
    logic         o_wb_err;
    logic         o_st_valid;
    logic         i_st_ready;
    logic [31:0]  o_st_adr;
    logic [31:0]  o_st_dat;
    logic [3:0]   o_st_sel;
    logic [3:0]   o_level;
    logic [31:0]  o_fetch_pc;

    int checks = 0;
    int errors = 0;

    amber_wb_inst_feeder u_dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_inst_valid (i_inst_valid),
        .o_inst_ready (o_inst_ready),
        .i_inst       (i_inst),
        .i_wb_adr     (i_wb_adr),
        .i_wb_sel     (i_wb_sel),
        .i_wb_we      (i_wb_we),
        .i_wb_dat     (i_wb_dat),
        .i_wb_cyc     (i_wb_cyc),
        .i_wb_stb     (i_wb_stb),
        .o_wb_dat     (o_wb_dat),
        .o_wb_ack     (o_wb_ack),
        .o_wb_err     (o_wb_err),
        .o_st_valid   (o_st_valid),
        .i_st_ready   (i_st_ready),
        .o_st_adr     (o_st_adr),
        .o_st_dat     (o_st_dat),
        .o_st_sel     (o_st_sel),
        .o_level      (o_level),
        .o_fetch_pc   (o_fetch_pc)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] w, input int lane);
        case (lane)
            0:       return {NOP, NOP, NOP, w};
            1:       return {NOP, NOP, w, NOP};
            2:       return {NOP, w, NOP, NOP};
            default: return {w, NOP, NOP, NOP};
        endcase
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                       input logic [127:0] dat);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_sel = sel;
        i_wb_dat = dat;
    endtask

    task automatic idle_bus();
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    initial begin
        int lvl;
        logic [31:0] w;

        i_rst_n      = 1'b0;
        i_inst_valid = 1'b0;
        i_inst       = '0;
        i_st_ready   = 1'b0;
        i_wb_adr     = '0;
        i_wb_sel     = '0;
        i_wb_dat     = '0;
        idle_bus();
        repeat (3) @(posedge i_clk);
        #1;

        // Reset values
        check("rst_ack",      128'(o_wb_ack),     128'd0);
        check("rst_err",      128'(o_wb_err),     128'd0);
        check("rst_st_valid", 128'(o_st_valid),   128'd0);
        check("rst_ready",    128'(o_inst_ready), 128'd1);
        check("rst_level",    128'(o_level),      128'd0);
        check("rst_dat",      o_wb_dat,           {4{NOP}});
        check("rst_pc",       128'(o_fetch_pc),   128'd0);
        check("rst_st_adr",   128'(o_st_adr),     128'd0);
        check("rst_st_dat",   128'(o_st_dat),     128'd0);
        check("rst_st_sel",   128'(o_st_sel),     128'd0);
        i_rst_n = 1'b1;
        tick();

        // Basic read, lane 1
        i_inst_valid = 1'b1;
        i_inst       = 32'hE3A01005;
        tick();
        i_inst_valid = 1'b0;
        check("push_level", 128'(o_level), 128'd1);
        req(1'b0, 32'h4, 16'h0, '0);
        tick();
        check("rd_ack", 128'(o_wb_ack), 128'd1);
        check("rd_dat", o_wb_dat, {NOP, NOP, 32'hE3A01005, NOP});
        check("rd_pc",  128'(o_fetch_pc), 128'h4);
        check("rd_pop_level", 128'(o_level), 128'd0);
        idle_bus();
        tick();
        check("rd_ack_one_cycle", 128'(o_wb_ack), 128'd0);
        check("rd_dat_hold", o_wb_dat, {NOP, NOP, 32'hE3A01005, NOP});

        // Empty-FIFO read
        req(1'b0, 32'h8, 16'h0, '0);
        tick();
`ifdef AMBER_FEED_NOP_ON_EMPTY_EN
        check("nop_ack",   128'(o_wb_ack), 128'd1);
        check("nop_dat",   o_wb_dat, {4{NOP}});
        check("nop_level", 128'(o_level), 128'd0);
        check("nop_pc",    128'(o_fetch_pc), 128'h8);
        idle_bus();
        tick();
`else
        check("empty_wait0", 128'(o_wb_ack), 128'd0);
        tick();
        check("empty_wait1", 128'(o_wb_ack), 128'd0);
        tick();
        check("empty_wait2", 128'(o_wb_ack), 128'd0);
        i_inst_valid = 1'b1;
        i_inst       = 32'hE0811002;
        tick();
        i_inst_valid = 1'b0;
        check("empty_level1", 128'(o_level), 128'd1);
        check("empty_wait3",  128'(o_wb_ack), 128'd0);
        tick();
        check("empty_ack",   128'(o_wb_ack), 128'd1);
        check("empty_dat",   o_wb_dat, line_of(32'hE0811002, 2));
        check("empty_level", 128'(o_level), 128'd0);
        check("empty_pc",    128'(o_fetch_pc), 128'h8);
        idle_bus();
        tick();

        // Push and request together on empty FIFO: two-cycle ack
        req(1'b0, 32'hC, 16'h0, '0);
        i_inst_valid = 1'b1;
        i_inst       = 32'h12345678;
        tick();
        i_inst_valid = 1'b0;
        check("same_cyc_wait", 128'(o_wb_ack), 128'd1 - 128'd1);
        tick();
        check("same_cyc_ack", 128'(o_wb_ack), 128'd1);
        check("same_cyc_dat", o_wb_dat, line_of(32'h12345678, 3));
        idle_bus();
        tick();
`endif

        // Store into free buffer
        req(1'b1, 32'h100, 16'h00F0, {32'h0, 32'h0, 32'h2A, 32'h0});
        tick();
        check("wr_ack",      128'(o_wb_ack),   128'd1);
        check("wr_st_valid", 128'(o_st_valid), 128'd1);
        check("wr_st_dat",   128'(o_st_dat),   128'h2A);
        check("wr_st_sel",   128'(o_st_sel),   128'hF);
        check("wr_st_adr",   128'(o_st_adr),   128'h100);
        idle_bus();
        tick();

        // Store while buffer full: held until drained
        req(1'b1, 32'h200, 16'hF000, {32'hDEADBEEF, 96'h0});
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wr_hold_noack", 128'(o_wb_ack), 128'd0);
        end
        check("wr_hold_old_dat", 128'(o_st_dat), 128'h2A);
        i_st_ready = 1'b1;
        tick();
        check("wr2_ack",      128'(o_wb_ack),   128'd1);
        check("wr2_st_valid", 128'(o_st_valid), 128'd1);
        check("wr2_st_dat",   128'(o_st_dat),   128'hDEADBEEF);
        check("wr2_st_adr",   128'(o_st_adr),   128'h200);
        check("wr2_st_sel",   128'(o_st_sel),   128'hF);
        idle_bus();
        tick();
        check("drain_valid", 128'(o_st_valid), 128'd0);
        i_st_ready = 1'b0;

        // Multi-lane select is an error
        req(1'b1, 32'h300, 16'h0F0F, {4{32'h11111111}});
        tick();
        check("err_pulse",    128'(o_wb_err),   128'd1);
        check("err_no_ack",   128'(o_wb_ack),   128'd0);
        check("err_no_cap",   128'(o_st_valid), 128'd0);
        idle_bus();
        tick();
        check("err_one_cycle", 128'(o_wb_err), 128'd0);
        check("err_st_adr",    128'(o_st_adr), 128'h200);

        // Empty select is an error too
        req(1'b1, 32'h304, 16'h0000, '0);
        tick();
        check("err0_pulse", 128'(o_wb_err),   128'd1);
        check("err0_nocap", 128'(o_st_valid), 128'd0);
        idle_bus();
        tick();

        // Fill to full
        i_inst_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_inst = 32'hA0000000 + 32'(i);
            tick();
        end
        check("full_level", 128'(o_level),      128'd8);
        check("full_ready", 128'(o_inst_ready), 128'd0);
        i_inst = 32'h00000BAD;
        tick();
        i_inst_valid = 1'b0;
        check("full_no_push", 128'(o_level), 128'd8);

        // Reset with a read outstanding
        req(1'b0, 32'h0, 16'h0, '0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_level", 128'(o_level),      128'd0);
        check("mid_rst_ready", 128'(o_inst_ready), 128'd1);
        check("mid_rst_ack",   128'(o_wb_ack),     128'd0);
        idle_bus();
        tick();
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_noack", 128'(o_wb_ack), 128'd0);
        end
        check("post_rst_level", 128'(o_level), 128'd0);

        // 20 words through the FIFO, pointers wrap
        i_inst_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            i_inst = 32'hC0DE0000 + 32'(j);
            tick();
        end
        i_inst_valid = 1'b0;
        lvl = 3;
        for (int i = 0; i < 20; i++) begin
            req(1'b0, 32'h1000 + 32'((i % 4) * 4), 16'h0, '0);
            if (i + 3 < 20) begin
                i_inst_valid = 1'b1;
                i_inst       = 32'hC0DE0000 + 32'(i + 3);
            end else begin
                lvl = lvl - 1;
            end
            tick();
            i_inst_valid = 1'b0;
            w = 32'hC0DE0000 + 32'(i);
            check("wrap_ack",   128'(o_wb_ack),   128'd1);
            check("wrap_dat",   o_wb_dat,         line_of(w, i % 4));
            check("wrap_level", 128'(o_level),    128'(lvl));
            check("wrap_pc",    128'(o_fetch_pc), 128'(32'h1000 + 32'((i % 4) * 4)));
            idle_bus();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
